pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 113 +++++++++++
 tb/tb_pc_stack_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with conditional/relative jumps and a call/return stack
module pc_stack_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int STACK_DEPTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1),
  localparam int ADDR_W = $clog2(STACK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [3:0]            flags,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [3:0]            sel;
  logic [3:0]            op;
  logic                  flag_n, flag_c, flag_z;
  logic [DATA_WIDTH-1:0] pc_inc, pc_rel, next_pc;
  logic                  push, pop, ovf_set, unf_set;
  logic [DEPTH_W-1:0]    depth_m1;
  logic [ADDR_W-1:0]     wr_idx, rd_idx;
  logic                  unused_bits;

  assign sel    = opcode[DATA_WIDTH-1:DATA_WIDTH-4];
  assign op     = opcode[DATA_WIDTH-5:DATA_WIDTH-8];
  assign flag_n = flags[2];
  assign flag_c = flags[1];
  assign flag_z = flags[0];
  assign unused_bits = ^{flags[3], opcode};

  assign pc_inc   = pc + 1'b1;
  assign pc_rel   = pc + operand;
  assign depth_m1 = depth - 1'b1;
  // Push/pop are gated by full/empty, so these indices never exceed STACK_DEPTH-1.
  assign wr_idx   = depth[ADDR_W-1:0];
  assign rd_idx   = depth_m1[ADDR_W-1:0];

  assign stack_full  = (depth == FULL_DEPTH);
  assign stack_empty = (depth == '0);

  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (sel == 4'h7) begin
      case (op)
        4'h0: next_pc = operand;
        4'h1: if (flag_c)  next_pc = operand;
        4'h2: if (flag_z)  next_pc = operand;
        4'h3: next_pc = pc_rel;
        4'h4: if (flag_c)  next_pc = pc_rel;
        4'h5: if (flag_z)  next_pc = pc_rel;
        4'h6: if (!flag_c) next_pc = operand;
        4'h7: if (!flag_z) next_pc = operand;
        4'h8: if (flag_n)  next_pc = operand;
        4'h9, 4'hA: begin
          if (stack_full) begin
            ovf_set = 1'b1;
          end else begin
            push    = 1'b1;
            next_pc = (op == 4'h9) ? operand : pc_rel;
          end
        end
        4'hB: begin
          if (stack_empty) begin
            unf_set = 1'b1;
          end else begin
            pop     = 1'b1;
            next_pc = stack_mem[rd_idx];
          end
        end
        default: next_pc = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_VECTOR;
      depth           <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      pc              <= next_pc;
      stack_overflow  <= stack_overflow | ovf_set;
      stack_underflow <= stack_underflow | unf_set;
      if (push)
        depth <= depth + 1'b1;
      else if (pop)
        depth <= depth_m1;
    end
  end

  // Entries need no reset: with depth=0 nothing can read them.
  always_ff @(posedge clk) begin
    if (!reset && !stall && push)
      stack_mem[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed self-checking bench for pc_stack_unit
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [15:0] opcode = '0;
  logic [15:0] operand = '0;
  logic [3:0]  flags = '0;
  logic [15:0] pc;
  logic [3:0]  depth;
  logic        stack_full, stack_empty, stack_overflow, stack_underflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_pc;
  logic [15:0] model_stk [$];

  localparam logic [15:0] NOP      = 16'h0000;
  localparam logic [15:0] JMP      = 16'h7000;
  localparam logic [15:0] JMPZ     = 16'h7200;
  localparam logic [15:0] JMP_REL  = 16'h7300;
  localparam logic [15:0] JMPNC    = 16'h7600;
  localparam logic [15:0] JMPN     = 16'h7800;
  localparam logic [15:0] CALL     = 16'h7900;
  localparam logic [15:0] CALL_REL = 16'h7A00;
  localparam logic [15:0] RET      = 16'h7B00;

  pc_stack_unit #(.DATA_WIDTH(16), .STACK_DEPTH(8), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .operand(operand),
    .flags(flags), .pc(pc), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] op, input logic [15:0] opd, input logic [3:0] fl);
    opcode  = op;
    operand = opd;
    flags   = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(NOP, 16'h0, 4'h0);
    check("rst_pc", pc, 16'h0000);
    check("rst_depth", depth, 0);
    check("rst_empty", stack_empty, 1);
    check("rst_full", stack_full, 0);
    check("rst_ovf", stack_overflow, 0);
    check("rst_unf", stack_underflow, 0);

    reset = 1'b0;
    step(NOP, 16'h0, 4'h0); check("seq1", pc, 16'h0001);
    step(NOP, 16'h0, 4'h0); check("seq2", pc, 16'h0002);
    step(NOP, 16'h0, 4'h0); check("seq3", pc, 16'h0003);
    step(16'h6900, 16'h0500, 4'h0); check("non_pc_sel", pc, 16'h0004);
    step(JMP, 16'hFFFF, 4'h0); check("jmp_ffff", pc, 16'hFFFF);
    step(NOP, 16'h0, 4'h0); check("wrap", pc, 16'h0000);

    step(JMP, 16'h0010, 4'h0);
    step(JMPZ, 16'h0040, 4'b0001); check("jmpz_taken", pc, 16'h0040);
    step(JMP, 16'h0010, 4'h0);
    step(JMPZ, 16'h0040, 4'b0000); check("jmpz_not", pc, 16'h0011);
    step(JMP, 16'h0010, 4'h0);
    step(JMPNC, 16'h0040, 4'b0010); check("jmpnc_not", pc, 16'h0011);
    step(JMPNC, 16'h0040, 4'b0000); check("jmpnc_taken", pc, 16'h0040);
    step(JMPZ, 16'h0080, 4'b1000); check("x_ignored", pc, 16'h0041);
    step(JMPN, 16'h0090, 4'b0100); check("jmpn_taken", pc, 16'h0090);

    step(JMP, 16'h0020, 4'h0);
    step(JMP_REL, 16'hFFF0, 4'h0); check("jmp_rel_neg", pc, 16'h0010);

    step(JMP, 16'h0005, 4'h0);
    step(CALL, 16'h0100, 4'h0); check("call1_pc", pc, 16'h0100);
    step(CALL, 16'h0200, 4'h0); check("call2_pc", pc, 16'h0200);
    check("call2_depth", depth, 2);
    step(RET, 16'h0, 4'h0); check("ret1_pc", pc, 16'h0101);
    check("ret1_depth", depth, 1);
    step(RET, 16'h0, 4'h0); check("ret2_pc", pc, 16'h0006);
    check("ret2_depth", depth, 0);
    step(CALL_REL, 16'h0010, 4'h0); check("callrel_pc", pc, 16'h0016);
    step(RET, 16'h0, 4'h0); check("callrel_ret", pc, 16'h0007);

    exp_pc = 16'h0007;
    for (int i = 0; i < 8; i++) begin
      model_stk.push_back(exp_pc + 16'h1);
      exp_pc = 16'h1000 + 16'(i * 16);
      step(CALL, exp_pc, 4'h0);
      check("fill_pc", pc, exp_pc);
    end
    check("full_depth", depth, 8);
    check("full_flag", stack_full, 1);
    check("full_no_ovf", stack_overflow, 0);
    step(CALL, 16'h2000, 4'h0);
    exp_pc = exp_pc + 16'h1;
    check("ovf_pc", pc, exp_pc);
    check("ovf_depth", depth, 8);
    check("ovf_flag", stack_overflow, 1);
    for (int i = 0; i < 8; i++) begin
      exp_pc = model_stk.pop_back();
      step(RET, 16'h0, 4'h0);
      check("drain_pc", pc, exp_pc);
    end
    check("drain_empty", stack_empty, 1);
    check("drain_no_unf", stack_underflow, 0);
    step(RET, 16'h0, 4'h0);
    check("unf_pc", pc, exp_pc + 16'h1);
    check("unf_depth", depth, 0);
    check("unf_flag", stack_underflow, 1);
    check("ovf_sticky", stack_overflow, 1);

    step(CALL, 16'h0300, 4'h0);
    stall = 1'b1;
    step(CALL, 16'h0400, 4'h0);
    check("stall_pc", pc, 16'h0300);
    check("stall_depth", depth, 1);
    reset = 1'b1;
    step(RET, 16'h0, 4'h0);
    check("rst_stall_pc", pc, 16'h0000);
    check("rst_stall_depth", depth, 0);
    check("rst_stall_ovf", stack_overflow, 0);
    check("rst_stall_unf", stack_underflow, 0);
    reset = 1'b0;
    stall = 1'b0;
    step(NOP, 16'h0, 4'h0); check("post_rst", pc, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
